// File: rtl/band_mac_sequencer.sv
// band_mac_sequencer
//   Time-multiplexes one serial MAC engine across NUM_BANDS equalizer bands.
//   Each accepted input sample costs one delay-line write cycle followed by
//   NUM_TAPS tap cycles for every band enabled in the captured mask. Enabled
//   bands are visited in ascending order with no idle cycle between them.
//   A per-band result strobe is delayed MAC_LAT enabled cycles so that it
//   lines up with the accumulator output.
//
// Ports
//   clk, rst       clock; synchronous active-high reset (overrides clk_enable)
//   clk_enable     advances all state; gates every output strobe
//   sample_valid   input sample offered
//   sample_ready   high in IDLE
//   band_mask      bands to compute, captured on transfer
//   wr_en/wr_addr  delay-line write strobe and write pointer
//   rd_addr        delay-line read address for the current tap
//   coef_band/tap  coefficient ROM select
//   acc_clr/acc_en accumulator load / accumulate strobes
//   out_valid/band accumulator result valid and its band tag
//   busy           sequence in flight or result still pending
`timescale 1ns/1ps

module band_mac_sequencer #(
  parameter int NUM_BANDS = 8,
  parameter int NUM_TAPS  = 64,
  parameter int MAC_LAT   = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          clk_enable,
  input  logic                                          sample_valid,
  output logic                                          sample_ready,
  input  logic [NUM_BANDS-1:0]                          band_mask,
  output logic                                          wr_en,
  output logic [((NUM_TAPS  > 1) ? $clog2(NUM_TAPS)  : 1)-1:0] wr_addr,
  output logic [((NUM_TAPS  > 1) ? $clog2(NUM_TAPS)  : 1)-1:0] rd_addr,
  output logic [((NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1)-1:0] coef_band,
  output logic [((NUM_TAPS  > 1) ? $clog2(NUM_TAPS)  : 1)-1:0] coef_tap,
  output logic                                          acc_clr,
  output logic                                          acc_en,
  output logic                                          out_valid,
  output logic [((NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1)-1:0] out_band,
  output logic                                          busy
);

  localparam int BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int TW = (NUM_TAPS  > 1) ? $clog2(NUM_TAPS)  : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    MAC   = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        wr_ptr, wr_ptr_nxt;
  logic [TW-1:0]        tap, tap_nxt;
  logic [BW-1:0]        band, band_nxt;
  logic [NUM_BANDS-1:0] mask, mask_nxt;
  logic                 push;
  logic [BW:0]          hit;
  logic [BW:0]          next_start;

  // Result-tag delay line: stage 0 is loaded on the last-tap cycle.
  logic [MAC_LAT-1:0]   pipe_vld;
  logic [BW-1:0]        pipe_band [MAC_LAT];

  // Lowest enabled band at index >= start; MSB of the result flags a hit.
  function automatic logic [BW:0] first_band(input logic [NUM_BANDS-1:0] m,
                                             input logic [BW:0]          start);
    logic [BW:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_BANDS; i++) begin
      if (!r[BW] && (i >= 32'(start)) && m[i]) begin
        r = {1'b1, BW'(i)};
      end
    end
    return r;
  endfunction

  assign next_start = {1'b0, band} + {{BW{1'b0}}, 1'b1};

  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    tap_nxt      = tap;
    band_nxt     = band;
    mask_nxt     = mask;
    push         = 1'b0;
    hit          = '0;
    sample_ready = 1'b0;
    wr_en        = 1'b0;
    acc_en       = 1'b0;
    acc_clr      = 1'b0;
    rd_addr      = '0;
    coef_band    = '0;
    coef_tap     = '0;

    // Next-state values are only committed when clk_enable is high, so the
    // IDLE branch below only takes effect on a real transfer.
    case (state)
      IDLE: begin
        sample_ready = 1'b1;
        if (sample_valid) begin
          state_nxt = WRITE;
          mask_nxt  = band_mask;
        end
      end

      WRITE: begin
        wr_en = clk_enable;
        hit   = first_band(mask, '0);
        if (hit[BW]) begin
          band_nxt  = hit[BW-1:0];
          tap_nxt   = '0;
          state_nxt = MAC;
        end else begin
          wr_ptr_nxt = wr_ptr + TW'(1);
          state_nxt  = IDLE;
        end
      end

      MAC: begin
        acc_en    = clk_enable;
        acc_clr   = clk_enable & (tap == '0);
        coef_band = band;
        coef_tap  = tap;
        rd_addr   = wr_ptr - tap;
        if (tap != TW'(NUM_TAPS - 1)) begin
          tap_nxt = tap + TW'(1);
        end else begin
          push    = 1'b1;
          tap_nxt = '0;
          hit     = first_band(mask, next_start);
          if (hit[BW]) begin
            band_nxt = hit[BW-1:0];
          end else begin
            wr_ptr_nxt = wr_ptr + TW'(1);
            state_nxt  = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      tap      <= '0;
      band     <= '0;
      mask     <= '0;
      pipe_vld <= '0;
      for (int unsigned i = 0; i < MAC_LAT; i++) begin
        pipe_band[i] <= '0;
      end
    end else if (clk_enable) begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      tap    <= tap_nxt;
      band   <= band_nxt;
      mask   <= mask_nxt;
      for (int unsigned i = MAC_LAT - 1; i > 0; i--) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_band[i] <= pipe_band[i-1];
      end
      pipe_vld[0]  <= push;
      pipe_band[0] <= push ? band : '0;
    end
  end

  assign wr_addr   = wr_ptr;
  assign out_valid = clk_enable & pipe_vld[MAC_LAT-1];
  assign out_band  = pipe_band[MAC_LAT-1];
  assign busy      = (state != IDLE) | (|pipe_vld);

endmodule

// File: tb/tb_band_mac_sequencer.sv
// tb_band_mac_sequencer
//   Directed vector table for the first cycles after reset, then scheduled
//   and randomized traffic checked every cycle against a schedule model:
//   each accepted sample expands into a list of expected enabled cycles
//   (one write, then NUM_TAPS taps per enabled band), and each finished band
//   produces a result expected MAC_LAT enabled cycles later.
`timescale 1ns/1ps

module tb_band_mac_sequencer;

  localparam int NB = 8;
  localparam int NT = 64;
  localparam int ML = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_enable;
  logic       sample_valid;
  logic       sample_ready;
  logic [7:0] band_mask;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [5:0] rd_addr;
  logic [2:0] coef_band;
  logic [5:0] coef_tap;
  logic       acc_clr;
  logic       acc_en;
  logic       out_valid;
  logic [2:0] out_band;
  logic       busy;

  always #5 clk = ~clk;

  band_mac_sequencer #(
    .NUM_BANDS (NB),
    .NUM_TAPS  (NT),
    .MAC_LAT   (ML)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_enable   (clk_enable),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .band_mask    (band_mask),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .coef_band    (coef_band),
    .coef_tap     (coef_tap),
    .acc_clr      (acc_clr),
    .acc_en       (acc_en),
    .out_valid    (out_valid),
    .out_band     (out_band),
    .busy         (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit       en;
    bit       sv;
    bit [7:0] m;
    bit       e_ready;
    bit       e_busy;
    bit       e_wr;
    bit       e_acc;
    bit       e_clr;
    bit [5:0] e_wa;
    bit [5:0] e_rd;
  } vec_t;

  vec_t vecs[11];

  // ---------------- schedule model ----------------
  typedef struct {
    bit       wr;
    bit       acc;
    bit       clr;
    bit [5:0] rd;
    bit [2:0] cb;
    bit [5:0] ct;
    bit       last_tap;
    bit       last;
  } op_t;

  typedef struct {
    longint   due;
    bit [2:0] band;
  } res_t;

  op_t    sched[$];
  res_t   outq[$];
  int     mptr     = 0;
  longint ecnt     = 0;
  int     accepted = 0;
  int     ov_count = 0;
  bit     tog      = 1'b0;

  task automatic build(input logic [7:0] m);
    op_t o;
    o = '{default: 0};
    o.wr = 1'b1;
    sched.push_back(o);
    for (int b = 0; b < NB; b++) begin
      if (m[b]) begin
        for (int t = 0; t < NT; t++) begin
          o          = '{default: 0};
          o.acc      = 1'b1;
          o.clr      = (t == 0);
          o.rd       = 6'((mptr - t + NT) % NT);
          o.cb       = 3'(b);
          o.ct       = 6'(t);
          o.last_tap = (t == NT - 1);
          sched.push_back(o);
        end
      end
    end
    sched[sched.size()-1].last = 1'b1;
    accepted++;
  endtask

  task automatic model_step();
    op_t h;
    bit  idle;
    bit  e_ov;
    idle = (sched.size() == 0);
    h    = '{default: 0};
    if (!idle) h = sched[0];
    e_ov = clk_enable && (outq.size() > 0) && (outq[0].due == ecnt);
    chk("sample_ready", sample_ready, idle);
    chk("busy", busy, !idle || (outq.size() > 0));
    chk("wr_en", wr_en, clk_enable & h.wr);
    chk("acc_en", acc_en, clk_enable & h.acc);
    chk("acc_clr", acc_clr, clk_enable & h.clr);
    chk("wr_addr", wr_addr, mptr);
    chk("out_valid", out_valid, e_ov);
    if (clk_enable && h.acc) begin
      chk("rd_addr", rd_addr, h.rd);
      chk("coef_band", coef_band, h.cb);
      chk("coef_tap", coef_tap, h.ct);
    end
    if (e_ov) chk("out_band", out_band, outq[0].band);
    if (out_valid === 1'b1) ov_count++;
    if (clk_enable) begin
      if (!idle) begin
        void'(sched.pop_front());
        if (h.last_tap) outq.push_back('{ecnt + ML, h.cb});
        if (h.last) mptr = (mptr + 1) % NT;
      end else if (sample_valid) begin
        build(band_mask);
      end
      if (e_ov) void'(outq.pop_front());
      ecnt++;
    end
  endtask

  task automatic cycle(input logic en, input logic sv, input logic [7:0] m);
    clk_enable   = en;
    sample_valid = sv;
    band_mask    = m;
    @(negedge clk);
    if (!rst) model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic en_for(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) begin
      tog = ~tog;
      return tog;
    end
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic send(input logic [7:0] m, input int mode);
    int start;
    int n;
    start = accepted;
    n     = 0;
    while (accepted == start && n < 100) begin
      cycle(en_for(mode), 1'b1, m);
      n++;
    end
    if (accepted == start) timeout("send");
  endtask

  task automatic drain(input int mode, input int budget);
    int n;
    n = 0;
    while ((sched.size() != 0 || outq.size() != 0) && n < budget) begin
      cycle(en_for(mode), 1'b0, 8'($urandom));
      n++;
    end
    if (sched.size() != 0 || outq.size() != 0) timeout("drain");
    repeat (3) cycle(1'b1, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b1, 1'b0, 8'h00);
    rst = 1'b0;
    sched.delete();
    outq.delete();
    mptr = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1, 0, 8'h00, 1, 0, 0, 0, 0, 6'd0, 6'd0};
    vecs[1]  = '{1, 1, 8'h00, 1, 0, 0, 0, 0, 6'd0, 6'd0};
    vecs[2]  = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 6'd0, 6'd0};
    vecs[3]  = '{1, 1, 8'hFF, 0, 1, 1, 0, 0, 6'd0, 6'd0};
    vecs[4]  = '{1, 0, 8'h00, 1, 0, 0, 0, 0, 6'd1, 6'd0};
    vecs[5]  = '{1, 1, 8'h01, 1, 0, 0, 0, 0, 6'd1, 6'd0};
    vecs[6]  = '{1, 0, 8'h00, 0, 1, 1, 0, 0, 6'd1, 6'd0};
    vecs[7]  = '{1, 0, 8'h00, 0, 1, 0, 1, 1, 6'd1, 6'd1};
    vecs[8]  = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 6'd1, 6'd0};
    vecs[9]  = '{1, 0, 8'h00, 0, 1, 0, 1, 0, 6'd1, 6'd0};
    vecs[10] = '{1, 0, 8'h00, 0, 1, 0, 1, 0, 6'd1, 6'd63};

    rst          = 1'b1;
    clk_enable   = 1'b1;
    sample_valid = 1'b0;
    band_mask    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and the first write/tap cycles, including gated strobes.
    for (int i = 0; i < 11; i++) begin
      clk_enable   = vecs[i].en;
      sample_valid = vecs[i].sv;
      band_mask    = vecs[i].m;
      @(negedge clk);
      chk("vec_ready", sample_ready, vecs[i].e_ready);
      chk("vec_busy", busy, vecs[i].e_busy);
      chk("vec_wr_en", wr_en, vecs[i].e_wr);
      chk("vec_acc_en", acc_en, vecs[i].e_acc);
      chk("vec_acc_clr", acc_clr, vecs[i].e_clr);
      chk("vec_out_valid", out_valid, 1'b0);
      chk("vec_wr_addr", wr_addr, vecs[i].e_wa);
      if (vecs[i].e_acc) chk("vec_rd_addr", rd_addr, vecs[i].e_rd);
      @(posedge clk);
      #1;
    end

    do_reset();

    // Single band.
    ov_count = 0;
    send(8'h01, 0);
    drain(0, 200);
    chk("single_band_results", ov_count, 1);

    // Sparse mask, then empty mask.
    ov_count = 0;
    send(8'hA5, 0);
    drain(0, 400);
    chk("a5_results", ov_count, 4);
    send(8'h00, 0);
    drain(0, 20);
    chk("empty_mask_wr_ptr", wr_addr, 3);

    // Back-to-back samples across the write-pointer wrap.
    ov_count = 0;
    begin
      int start;
      int n;
      start = accepted;
      n     = 0;
      while (accepted - start < 65 && n < 65 * 70) begin
        cycle(1'b1, 1'b1, 8'h01);
        n++;
      end
      if (accepted - start < 65) timeout("wrap_samples");
    end
    drain(0, 200);
    chk("wrap_results", ov_count, 65);

    // Same sparse mask with clock enable toggling every cycle.
    ov_count = 0;
    send(8'hA5, 1);
    drain(1, 800);
    chk("stretched_results", ov_count, 4);

    // Random traffic: enable, offers and masks all random.
    for (int i = 0; i < 6000; i++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), 8'($urandom));
    end
    drain(2, 5000);

    // Reset in the middle of band 2.
    send(8'hA5, 0);
    begin
      int n;
      n = 0;
      while (!(sched.size() > 0 && sched[0].acc && sched[0].cb == 3'd2 && sched[0].ct == 6'd30)
             && n < 400) begin
        cycle(1'b1, 1'b0, 8'h00);
        n++;
      end
      if (n >= 400) timeout("reach_band2_tap30");
    end
    do_reset();
    ov_count = 0;
    repeat (10) cycle(1'b1, 1'b0, 8'h00);
    chk("post_reset_results", ov_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
